// File: rtl/pristis_pkg.sv
// Shared definitions for the pristis lane-strobe skew monitor.
package pristis_pkg;

  // Monitor FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t StIdle      = 2'd0;
  localparam state_t StWaitFirst = 2'd1;
  localparam state_t StCollect   = 2'd2;
  localparam state_t StReport    = 2'd3;

  // Bit position of each pristis_top strobe within meascnt
  localparam int unsigned LANE_0_1 = 0;
  localparam int unsigned LANE_2_3 = 1;
  localparam int unsigned LANE_4_5 = 2;
  localparam int unsigned LANE_6_7 = 3;

  // Default counter width and forced-report timeout
  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefTimeout = 1024;

endpackage

// File: rtl/pristis_edge_det.sv
// Two-stage strobe register with rising-edge detect. Strobes are already
// synchronous to clk, so this is a fixed pipeline, not a synchronizer.
module pristis_edge_det #(
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_LANES-1:0] strobe_i,
  output logic [NUM_LANES-1:0] rise_o
);

  logic [NUM_LANES-1:0] s1_q, s1_d;
  logic [NUM_LANES-1:0] s2_q, s2_d;

  // Shift the strobes through the two stages
  always_comb begin
    s1_d = strobe_i;
    s2_d = s1_q;
  end

  // Stage registers, cleared on reset so no spurious edge follows release
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign rise_o = s1_q & ~s2_q;

endmodule

// File: rtl/pristis_skew_monitor.sv
// Timestamps the first rising edge of each lane strobe relative to the
// earliest lane after every delay change or arm, and reports per-lane
// offsets plus worst-case skew over a valid/ready interface.
module pristis_skew_monitor
  import pristis_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic [31:0]                delay,
  input  logic [NUM_LANES-1:0]       meascnt,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [NUM_LANES*CNT_W-1:0] res_offset,
  output logic [CNT_W-1:0]           res_skew,
  output logic [NUM_LANES-1:0]       res_mask,
  output logic                       res_timeout,
  output logic [31:0]                res_delay
);

  localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                          state_q, state_d;
  logic [31:0]                     delay_q;
  logic                            pending_q, pending_d;
  logic [NUM_LANES-1:0]            mask_q, mask_d;
  logic [NUM_LANES-1:0][CNT_W-1:0] offset_q, offset_d;
  logic [CNT_W-1:0]                rel_q, rel_d;
  logic [TmoW-1:0]                 tmo_q, tmo_d;
  logic [CNT_W-1:0]                skew_q, skew_d;
  logic                            timeout_q, timeout_d;
  logic [31:0]                     rdelay_q, rdelay_d;

  logic [NUM_LANES-1:0] rise;
  logic                 start;
  logic                 launch;
  logic                 tmo_hit;

  pristis_edge_det #(
    .NUM_LANES(NUM_LANES)
  ) u_edge_det (
    .clk_i   (clk),
    .rst_i   (reset),
    .strobe_i(meascnt),
    .rise_o  (rise)
  );

  function automatic logic [CNT_W-1:0] max_off(input logic [NUM_LANES-1:0][CNT_W-1:0] off,
                                               input logic [NUM_LANES-1:0]            msk);
    logic [CNT_W-1:0] mx;
    mx = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (msk[i] && (off[i] > mx)) mx = off[i];
    end
    return mx;
  endfunction

  assign start   = arm | (delay != delay_q);
  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT - 1));

  // Measurement FSM and capture datapath next-state
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mask_d    = mask_q;
    offset_d  = offset_q;
    rel_d     = rel_q;
    tmo_d     = tmo_q;
    skew_d    = skew_q;
    timeout_d = timeout_q;
    rdelay_d  = rdelay_q;
    launch    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start || pending_q) launch = 1'b1;
      end
      StWaitFirst, StCollect: begin
        // A new start abandons the running measurement without reporting
        if (start) begin
          launch = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (state_q == StWaitFirst) begin
            if (|rise) begin
              mask_d  = rise;
              rel_d   = CNT_W'(1);
              state_d = StCollect;
            end
          end else begin
            if (rel_q != '1) rel_d = rel_q + 1'b1;
            for (int i = 0; i < int'(NUM_LANES); i++) begin
              if (rise[i] && !mask_q[i]) begin
                offset_d[i] = rel_q;
                mask_d[i]   = 1'b1;
              end
            end
          end
          // Edges seen this cycle are captured before the timeout decision
          if ((mask_d == '1) || tmo_hit) begin
            state_d   = StReport;
            timeout_d = (mask_d != '1);
            skew_d    = max_off(offset_d, mask_d);
          end
        end
      end
      StReport: begin
        if (start) pending_d = 1'b1;
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d   = StWaitFirst;
      pending_d = 1'b0;
      mask_d    = '0;
      offset_d  = '0;
      rel_d     = '0;
      tmo_d     = '0;
      skew_d    = '0;
      timeout_d = 1'b0;
      rdelay_d  = delay;
    end
  end

  // State and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      delay_q   <= '0;
      pending_q <= 1'b0;
      mask_q    <= '0;
      offset_q  <= '0;
      rel_q     <= '0;
      tmo_q     <= '0;
      skew_q    <= '0;
      timeout_q <= 1'b0;
      rdelay_q  <= '0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      offset_q  <= offset_d;
      rel_q     <= rel_d;
      tmo_q     <= tmo_d;
      skew_q    <= skew_d;
      timeout_q <= timeout_d;
      rdelay_q  <= rdelay_d;
    end
  end

  assign busy        = (state_q == StWaitFirst) || (state_q == StCollect);
  assign res_valid   = (state_q == StReport);
  assign res_offset  = offset_q;
  assign res_skew    = skew_q;
  assign res_mask    = mask_q;
  assign res_timeout = timeout_q;
  assign res_delay   = rdelay_q;

endmodule

// File: tb/tb_pristis_skew_monitor.sv
// Bench for pristis_skew_monitor: directed vector table, hand sequences for
// abort/backpressure/reset, then random traffic against a timestamp model.
module tb_pristis_skew_monitor;

  localparam int unsigned TIMEOUT = 1024;
  localparam logic [15:0] NEVER   = 16'hFFFF;

  logic        clk;
  logic        reset;
  logic        arm;
  logic [31:0] delay;
  logic [3:0]  meascnt;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_offset;
  logic [15:0] res_skew;
  logic [3:0]  res_mask;
  logic        res_timeout;
  logic [31:0] res_delay;

  pristis_skew_monitor #(
    .NUM_LANES(4),
    .CNT_W    (16),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .delay      (delay),
    .meascnt    (meascnt),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_offset (res_offset),
    .res_skew   (res_skew),
    .res_mask   (res_mask),
    .res_timeout(res_timeout),
    .res_delay  (res_delay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: measurements described by absolute arrival timestamps
  int          cyc;
  int          ph;        // 0 idle, 1 measuring, 2 reporting
  int          st;        // cycle number of the start edge
  int          arr_m[4];  // cycle a lane's edge was seen, -1 if not yet
  bit          pend;
  logic [31:0] dq;
  logic [3:0]  m1, m2;
  logic [63:0] e_off;
  logic [15:0] e_skew;
  logic [3:0]  e_mask;
  logic        e_to;
  logic [31:0] e_dly;

  task automatic m_reset();
    ph = 0; pend = 0; dq = '0; m1 = '0; m2 = '0;
    e_off = '0; e_skew = '0; e_mask = '0; e_to = 1'b0; e_dly = '0;
  endtask

  task automatic m_begin();
    ph = 1; st = cyc; e_dly = delay;
    for (int i = 0; i < 4; i++) arr_m[i] = -1;
  endtask

  task automatic m_finish(input bit full);
    int first;
    int o;
    first = 32'h7fffffff;
    for (int i = 0; i < 4; i++) if (arr_m[i] >= 0 && arr_m[i] < first) first = arr_m[i];
    e_off = '0; e_mask = '0; e_skew = '0;
    for (int i = 0; i < 4; i++) begin
      if (arr_m[i] >= 0) begin
        o = arr_m[i] - first;
        if (o > 65535) o = 65535;
        e_off[i*16 +: 16] = 16'(o);
        e_mask[i] = 1'b1;
        if (16'(o) > e_skew) e_skew = 16'(o);
      end
    end
    e_to = !full;
    ph = 2;
  endtask

  task automatic m_edge();
    logic [3:0] rs;
    bit strt;
    bit full;
    rs = m1 & ~m2;
    m2 = m1;
    m1 = meascnt;
    strt = arm || (delay != dq);
    dq = delay;
    case (ph)
      0: if (strt || pend) begin m_begin(); pend = 0; end
      1: begin
        if (strt) m_begin();
        else begin
          for (int i = 0; i < 4; i++) if (rs[i] && arr_m[i] < 0) arr_m[i] = cyc;
          full = 1;
          for (int i = 0; i < 4; i++) if (arr_m[i] < 0) full = 0;
          if (full || (cyc - st - 1 == int'(TIMEOUT) - 1)) m_finish(full);
        end
      end
      default: begin
        if (strt) pend = 1;
        if (res_ready) ph = 0;
      end
    endcase
  endtask

  // One clock: advance the model at the edge, compare 1 time unit later
  task automatic step();
    @(posedge clk);
    cyc++;
    if (reset) m_reset();
    else m_edge();
    #1;
    chk("busy", busy, ph == 1);
    chk("valid", res_valid, ph == 2);
    if (ph == 2) begin
      chk("offset", res_offset, e_off);
      chk("skew", res_skew, e_skew);
      chk("mask", res_mask, e_mask);
      chk("timeout", res_timeout, e_to);
      chk("res_delay", res_delay, e_dly);
    end
  endtask

  // Called right after a start edge; raises each lane from its arrival cycle on
  task automatic run_meas(input logic [3:0][15:0] arr, input int maxc, output bit got,
                          output int lat);
    int n0;
    n0 = cyc;
    got = 0;
    lat = -1;
    for (int c = 1; c <= maxc && !got; c++) begin
      for (int i = 0; i < 4; i++) if (arr[i] != NEVER && c >= int'(arr[i])) meascnt[i] = 1'b1;
      step();
      if (res_valid) begin
        got = 1;
        lat = cyc - n0;
      end
    end
    chk("report_seen", 64'(got), 64'd1);
  endtask

  typedef struct {
    logic             use_arm;
    logic [31:0]      dly;
    logic [3:0][15:0] arr;
    int               lat;
    logic [63:0]      off;
    logic [15:0]      skew;
    logic [3:0]       mask;
    logic             to;
  } vec_t;

  vec_t tv[8];
  bit   got;
  int   lat;

  initial begin
    tv[0] = '{1'b0, 32'd10, {16'd27, 16'd20, 16'd23, 16'd20}, 28,
              {16'd7, 16'd0, 16'd3, 16'd0}, 16'd7, 4'hF, 1'b0};
    tv[1] = '{1'b1, 32'd10, {16'd4, 16'd4, 16'd4, 16'd4}, 5,
              64'd0, 16'd0, 4'hF, 1'b0};
    tv[2] = '{1'b0, 32'd11, {16'd9, NEVER, 16'd8, 16'd5}, 1024,
              {16'd4, 16'd0, 16'd3, 16'd0}, 16'd4, 4'hB, 1'b1};
    tv[3] = '{1'b0, 32'd12, {16'd9, 16'd17, 16'd2, 16'd30}, 31,
              {16'd7, 16'd15, 16'd0, 16'd28}, 16'd28, 4'hF, 1'b0};
    tv[4] = '{1'b0, 32'd13, {16'd1, 16'd1, 16'd1, 16'd1}, 2,
              64'd0, 16'd0, 4'hF, 1'b0};
    tv[5] = '{1'b0, 32'd14, {16'd300, 16'd200, 16'd1023, 16'd100}, 1024,
              {16'd200, 16'd100, 16'd923, 16'd0}, 16'd923, 4'hF, 1'b0};
    tv[6] = '{1'b0, 32'd15, {16'd300, 16'd200, 16'd1024, 16'd100}, 1024,
              {16'd200, 16'd100, 16'd0, 16'd0}, 16'd200, 4'hD, 1'b1};
    tv[7] = '{1'b0, 32'd16, {NEVER, 16'd200, 16'd1023, 16'd100}, 1024,
              {16'd0, 16'd100, 16'd923, 16'd0}, 16'd923, 4'h7, 1'b1};

    cyc = 0;
    reset = 1'b1; arm = 1'b0; delay = '0; meascnt = '0; res_ready = 1'b0;
    m_reset();
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_offset", res_offset, 0);
    chk("rst_skew", res_skew, 0);
    chk("rst_mask", res_mask, 0);
    chk("rst_timeout", res_timeout, 0);
    chk("rst_delay", res_delay, 0);
    reset = 1'b0;
    repeat (2) step();

    // Directed vector table
    for (int r = 0; r < 8; r++) begin
      meascnt = '0;
      repeat (3) step();
      if (tv[r].use_arm) arm = 1'b1;
      else delay = tv[r].dly;
      step();
      arm = 1'b0;
      run_meas(tv[r].arr, 1200, got, lat);
      if (got) begin
        chk("vec_latency", 64'(lat), 64'(tv[r].lat));
        chk("vec_offset", res_offset, tv[r].off);
        chk("vec_skew", res_skew, tv[r].skew);
        chk("vec_mask", res_mask, tv[r].mask);
        chk("vec_timeout", res_timeout, tv[r].to);
        chk("vec_delay", res_delay, tv[r].dly);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
    end

    // Delay change mid-collection abandons the old measurement
    meascnt = '0;
    repeat (3) step();
    delay = 32'd1;
    step();
    for (int c = 1; c <= 7; c++) begin
      meascnt[0] = (c >= 3);
      meascnt[1] = (c >= 5);
      step();
    end
    chk("abort_pre_busy", busy, 1);
    delay = 32'd2;
    meascnt = '0;
    step();
    chk("abort_valid", res_valid, 0);
    chk("abort_busy", busy, 1);
    chk("abort_delay", res_delay, 32'd2);
    run_meas({16'd9, 16'd6, 16'd6, 16'd4}, 60, got, lat);
    chk("abort_offset", res_offset, {16'd5, 16'd2, 16'd2, 16'd0});
    chk("abort_skew", res_skew, 16'd5);
    chk("abort_rdelay", res_delay, 32'd2);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Backpressure in REPORT while the delay changes underneath
    meascnt = '0;
    repeat (3) step();
    delay = 32'd20;
    step();
    run_meas({16'd5, 16'd4, 16'd3, 16'd2}, 60, got, lat);
    for (int k = 0; k < 50; k++) begin
      if (k == 10) delay = 32'd21;
      step();
    end
    chk("bp_valid", res_valid, 1);
    chk("bp_delay", res_delay, 32'd20);
    chk("bp_skew", res_skew, 16'd3);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("bp_hs_valid", res_valid, 0);
    chk("bp_hs_busy", busy, 0);
    step();
    chk("bp_pending_busy", busy, 1);
    chk("bp_pending_delay", res_delay, 32'd21);

    // Reset while collecting, then a clean measurement
    meascnt = '0;
    repeat (2) step();
    meascnt[0] = 1'b1;
    repeat (3) step();
    chk("rst_pre_busy", busy, 1);
    reset = 1'b1;
    m_reset();
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", res_valid, 0);
    chk("rst_mid_mask", res_mask, 0);
    meascnt = '0;
    repeat (2) step();
    reset = 1'b0;
    step();
    run_meas({16'd4, 16'd5, 16'd7, 16'd3}, 60, got, lat);
    chk("post_rst_offset", res_offset, {16'd1, 16'd2, 16'd4, 16'd0});
    chk("post_rst_skew", res_skew, 16'd4);
    chk("post_rst_delay", res_delay, 32'd21);
    res_ready = 1'b1;
    step();

    // Random traffic against the model
    for (int k = 0; k < 6000; k++) begin
      int l;
      arm = ($urandom_range(0, 199) < ((k < 3000) ? 3 : 1));
      if ($urandom_range(0, 299) == 0) delay = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        l = $urandom_range(0, 3);
        meascnt[l] = ~meascnt[l];
      end
      res_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    arm = 1'b0;
    res_ready = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
